// File: rtl/piccolo80_keysched.sv
// piccolo80_keysched: Piccolo-80 round-key pair and whitening-key generator (optional decrypt ordering via PICCOLO_KS_DEC_EN)
module piccolo80_keysched #(
  parameter int ROUNDS = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [0:79] key,
  input  logic        dec,
  output logic        busy,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [0:31] rk,
  output logic [4:0]  rk_idx,
  output logic [0:31] wk_pre,
  output logic [0:31] wk_post,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [4:0] LAST = 5'(ROUNDS - 1);
  state_t      state_q;
  logic [0:79] key_q;
  logic [4:0]  i_q, i_n, i0;
  logic [2:0]  m_q, m_n, m0;
  logic [0:31] rk_q;
  logic [4:0]  rk_idx_q;
  logic        busy_q, valid_q, done_q, last;
  logic        dec_in, dec_s;
  logic [0:31] wk01, wk23;
  function automatic logic [0:31] pair_f(input logic [0:79] k, input logic [4:0] i, input logic [2:0] m, input logic sw);
    logic [4:0]  c;
    logic [0:31] con, sel, r;
    c   = i + 5'd1;
    con = {c, 5'd0, c, 2'b00, c, 5'd0, c} ^ 32'h0F1E2D3C;
    sel = (m == 3'd3) ? {k[64:79], k[64:79]} : (m == 3'd1 || m == 3'd4) ? k[0:31] : k[32:63];
    r   = con ^ sel;
    return sw ? {r[16:31], r[0:15]} : r;
  endfunction
`ifdef PICCOLO_KS_DEC_EN
  logic dec_q;
  assign dec_in = dec;
  assign dec_s  = dec_q;
  // decrypt flag is captured together with the key on an accepted start
  always_ff @(posedge clk or negedge reset)
    if (!reset) dec_q <= 1'b0;
    else if (state_q == IDLE && start) dec_q <= dec;
`else
  logic unused_dec;
  assign unused_dec = dec;
  assign dec_in     = 1'b0;
  assign dec_s      = 1'b0;
`endif
  // next round index and key-word selector, stepping in the schedule direction
  always_comb begin
    i_n  = dec_s ? i_q - 5'd1 : i_q + 5'd1;
    m_n  = dec_s ? ((m_q == 3'd0) ? 3'd4 : m_q - 3'd1) : ((m_q == 3'd4) ? 3'd0 : m_q + 3'd1);
    last = (i_q == (dec_s ? 5'd0 : LAST));
    i0   = dec_in ? LAST : 5'd0;
    m0   = dec_in ? 3'd4 : 3'd0;
  end
  // schedule FSM; rk is precomputed for the index about to be presented
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      key_q    <= '0;
      i_q      <= '0;
      m_q      <= '0;
      rk_q     <= '0;
      rk_idx_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q  <= RUN;
          key_q    <= key;
          i_q      <= i0;
          m_q      <= m0;
          rk_q     <= pair_f(key, i0, m0, 1'b0);
          rk_idx_q <= i0;
          busy_q   <= 1'b1;
          valid_q  <= 1'b1;
        end
        RUN: if (rk_ready) begin
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            i_q      <= i_n;
            m_q      <= m_n;
            rk_q     <= pair_f(key_q, i_n, m_n, dec_s & i_n[0]);
            rk_idx_q <= i_n;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
  assign wk01     = {key_q[0:7], key_q[24:31], key_q[16:23], key_q[8:15]};
  assign wk23     = {key_q[64:71], key_q[56:63], key_q[48:55], key_q[72:79]};
  assign wk_pre   = dec_s ? wk23 : wk01;
  assign wk_post  = dec_s ? wk01 : wk23;
  assign rk       = rk_q;
  assign rk_idx   = rk_idx_q;
  assign busy     = busy_q;
  assign rk_valid = valid_q;
  assign done     = done_q;
endmodule

// File: tb/tb_piccolo80_keysched.sv
// tb_piccolo80_keysched: directed scoreboard bench for the Piccolo-80 key schedule
module tb_piccolo80_keysched;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [0:79] key = '0;
  logic        dec = 1'b0;
  logic        rk_ready = 1'b0;
  logic        busy, rk_valid, done;
  logic [0:31] rk, wk_pre, wk_post;
  logic [4:0]  rk_idx;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cnt;
  logic [36:0] q[$];
  logic [0:31] saved;
  localparam logic [79:0] K1 = 80'h00112233445566778899;
  localparam logic [79:0] K2 = 80'hDEADBEEFCAFEF00D1234;
  piccolo80_keysched dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .dec(dec),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk),
    .rk_idx(rk_idx), .wk_pre(wk_pre), .wk_post(wk_post), .done(done)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mdl(input logic [79:0] k, input int i, input bit sw);
    logic [4:0]  c;
    logic [31:0] con, sel, r;
    c   = 5'(i + 1);
    con = {c, 5'b0, c, 2'b0, c, 5'b0, c} ^ 32'h0F1E2D3C;
    case (i % 5)
      0, 2:    sel = k[47:16];
      1, 4:    sel = k[79:48];
      default: sel = {k[15:0], k[15:0]};
    endcase
    r = con ^ sel;
    return sw ? {r[15:0], r[31:16]} : r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic push_sched(input logic [79:0] k, input bit d);
    for (int j = 0; j < 25; j++) begin
      int i;
      i = d ? 24 - j : j;
      q.push_back({5'(i), mdl(k, i, d && (j % 2 == 1))});
    end
  endtask
  task automatic clk_step();
    logic [36:0] e;
    @(negedge clk);
    if (rk_valid && rk_ready) begin
      e = (q.size() != 0) ? q.pop_front() : 'x;
      chk("sb_rk", rk, e[31:0]);
      chk("sb_idx", 32'(rk_idx), 32'(e[36:32]));
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input logic [79:0] k, input bit d);
    key = k; dec = d; start = 1'b1;
    clk_step();
    start = 1'b0;
  endtask
  task automatic run_to_done();
    cnt = 0;
    while (!done && cnt < 60) begin clk_step(); cnt++; end
    chk("done_seen", 32'(done), 32'd1);
    chk("sb_drained", q.size(), 32'd0);
  endtask
  initial begin
    #2;
    chk("rst_ctl", {29'd0, busy, rk_valid, done}, 32'd0);
    chk("rst_rk", rk, 32'd0);
    chk("rst_idx", 32'(rk_idx), 32'd0);
    chk("rst_wk", wk_pre | wk_post, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    clk_step();
    rk_ready = 1'b1;
    do_start(K1, 1'b0);
    push_sched(K1, 1'b0);
    chk("start_busy", {30'd0, busy, rk_valid}, 32'd3);
    chk("pair0_vec", rk, 32'h43494F4A);
    chk("wk_pre_enc", wk_pre, 32'h00332211);
    chk("wk_post_enc", wk_post, 32'h88776699);
    cnt = 0;
    while (rk_idx != 5'd5 && cnt < 40) begin clk_step(); cnt++; end
    chk("reach5", 32'(rk_idx), 32'd5);
    rk_ready = 1'b0;
    saved = rk;
    for (int h = 0; h < 3; h++) begin
      clk_step();
      chk("bp_rk", rk, saved);
      chk("bp_idx", 32'(rk_idx), 32'd5);
      chk("bp_valid", 32'(rk_valid), 32'd1);
    end
    rk_ready = 1'b1;
    clk_step();
    chk("bp_next_idx", 32'(rk_idx), 32'd6);
    chk("bp_next_rk", rk, mdl(K1, 6, 1'b0));
    cnt = 0;
    while (rk_idx != 5'd10 && cnt < 40) begin clk_step(); cnt++; end
    chk("reach10", 32'(rk_idx), 32'd10);
    do_start(K2, 1'b0);
    chk("ign_wk", wk_pre, 32'h00332211);
    cnt = 0;
    while (rk_idx != 5'd24 && cnt < 40) begin clk_step(); cnt++; end
    chk("pair24_vec", rk, 32'hC73D6B16);
    run_to_done();
    clk_step();
    chk("done_pulse", {30'd0, done, busy}, 32'd0);
    do_start(K1, 1'b0);
    push_sched(K1, 1'b0);
    cnt = 0;
    while (!done && cnt < 40) begin clk_step(); cnt++; end
    chk("done_latency", cnt, 32'd25);
    chk("sb_drained2", q.size(), 32'd0);
    clk_step();
    do_start(K2, 1'b0);
    push_sched(K2, 1'b0);
    cnt = 0;
    while (rk_idx != 5'd7 && cnt < 40) begin clk_step(); cnt++; end
    chk("reach7", 32'(rk_idx), 32'd7);
    reset = 1'b0;
    #1;
    chk("arst_ctl", {29'd0, busy, rk_valid, done}, 32'd0);
    chk("arst_rk", rk, 32'd0);
    chk("arst_idx", 32'(rk_idx), 32'd0);
    chk("arst_wk", wk_pre | wk_post, 32'd0);
    q.delete();
    clk_step();
    reset = 1'b1;
    clk_step();
    chk("post_rst_idle", {30'd0, busy, rk_valid}, 32'd0);
    do_start(K1, 1'b0);
    push_sched(K1, 1'b0);
    chk("post_rst_pair0", rk, 32'h43494F4A);
    run_to_done();
    clk_step();
`ifdef PICCOLO_KS_DEC_EN
    do_start(K1, 1'b1);
    push_sched(K1, 1'b1);
    chk("dec_first", rk, 32'hC73D6B16);
    chk("dec_first_idx", 32'(rk_idx), 32'd24);
    chk("dec_wk_pre", wk_pre, 32'h88776699);
    chk("dec_wk_post", wk_post, 32'h00332211);
    clk_step();
    chk("dec_second", rk, {mdl(K1, 23, 1'b0)[15:0], mdl(K1, 23, 1'b0)[31:16]});
    cnt = 0;
    while (rk_idx != 5'd0 && cnt < 40) begin clk_step(); cnt++; end
    chk("dec_last", rk, 32'h43494F4A);
    run_to_done();
`else
    do_start(K1, 1'b1);
    push_sched(K1, 1'b0);
    chk("nodec_first", rk, 32'h43494F4A);
    chk("nodec_wk_pre", wk_pre, 32'h00332211);
    run_to_done();
`endif
    clk_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
